// File: rtl/cic_pkg.sv
// Shared constants for the CIC pooling/flatten stage: memory selects, geometry,
// data widths and the pooling FSM state encoding.
package cic_pkg;

  localparam int IMG_W  = 64;
  localparam int POOL_W = 32;
  localparam int DW     = 20;
  localparam int AW     = 12;

  localparam logic [2:0] NSEL = 3'b000;
  localparam logic [2:0] L0K0 = 3'b001;
  localparam logic [2:0] L0K1 = 3'b010;
  localparam logic [2:0] L1K0 = 3'b011;
  localparam logic [2:0] L1K1 = 3'b100;
  localparam logic [2:0] L2F  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CMP,
    S_WL1,
    S_WL2,
    S_DONE
  } state_t;

endpackage

// File: rtl/cic_smax.sv
// Combinational signed two-input max; on a tie the 'a' operand (earlier sample) wins.
module cic_smax #(
  parameter int DW = 20
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/cic_pool_flatten.sv
// 2x2 stride-2 max-pool of both Layer 0 maps into Layer 1, with the interleaved
// Layer 2 flatten write enabled by defining CIC_POOL_FLATTEN_EN.
module cic_pool_flatten
  import cic_pkg::*;
#(
  parameter int IMG_W = cic_pkg::IMG_W,
  parameter int DW    = cic_pkg::DW,
  parameter int AW    = cic_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int PW = IMG_W / 2;
  localparam int CB = $clog2(PW);
  localparam logic [CB-1:0] LAST = CB'(PW - 1);

  state_t          state, state_nx;
  logic            kern;
  logic [CB-1:0]   row, col;
  logic [DW-1:0]   max_q, max_nx;
  logic [AW-1:0]   base_addr, rd_addr;
  logic            win_end, last_win;

  // With power-of-two IMG_W, 2r*IMG_W + 2c is just a bit concatenation.
  assign base_addr = AW'({row, 1'b0, col, 1'b0});

  always_comb begin
    rd_addr = base_addr;
    case (state)
      S_RD1:   rd_addr = base_addr + AW'(1);
      S_RD2:   rd_addr = base_addr + AW'(IMG_W);
      S_RD3:   rd_addr = base_addr + AW'(IMG_W + 1);
      default: rd_addr = base_addr;
    endcase
  end

  cic_smax #(.DW(DW)) u_smax (
    .a(max_q),
    .b(cdata_rd),
    .y(max_nx)
  );

`ifdef CIC_POOL_FLATTEN_EN
  assign win_end = (state == S_WL2);
`else
  assign win_end = (state == S_WL1);
`endif
  assign last_win = kern && (row == LAST) && (col == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RD0;
      S_RD0:   state_nx = S_RD1;
      S_RD1:   state_nx = S_RD2;
      S_RD2:   state_nx = S_RD3;
      S_RD3:   state_nx = S_CMP;
      S_CMP:   state_nx = S_WL1;
`ifdef CIC_POOL_FLATTEN_EN
      S_WL1:   state_nx = S_WL2;
      S_WL2:   state_nx = last_win ? S_DONE : S_RD0;
`else
      S_WL1:   state_nx = last_win ? S_DONE : S_RD0;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Each read's data lands one edge later, so RD1 seeds the max and RD2..CMP fold in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      kern  <= 1'b0;
      row   <= '0;
      col   <= '0;
      max_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          kern <= 1'b0;
          row  <= '0;
          col  <= '0;
        end
        S_RD1:               max_q <= cdata_rd;
        S_RD2, S_RD3, S_CMP: max_q <= max_nx;
        default: ;
      endcase
      if (win_end) begin
        col <= col + 1'b1;
        if (col == LAST) begin
          row <= row + 1'b1;
          if (row == LAST) kern <= ~kern;
        end
      end
    end
  end

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign crd      = (state == S_RD0) || (state == S_RD1) || (state == S_RD2) || (state == S_RD3);
  assign caddr_rd = crd ? rd_addr : '0;
  assign cwr      = (state == S_WL1) || (state == S_WL2);

  always_comb begin
    csel     = NSEL;
    caddr_wr = '0;
    cdata_wr = '0;
    case (state)
      S_RD0, S_RD1, S_RD2, S_RD3: csel = kern ? L0K1 : L0K0;
      S_WL1: begin
        csel     = kern ? L1K1 : L1K0;
        caddr_wr = AW'({row, col});
        cdata_wr = max_q;
      end
`ifdef CIC_POOL_FLATTEN_EN
      S_WL2: begin
        csel     = L2F;
        caddr_wr = AW'({row, col, kern});
        cdata_wr = max_q;
      end
`endif
      default: ;
    endcase
  end

endmodule
